// File: rtl/fizzbuzz_ascii_tx.sv
// Formats one fizzbuzz result per handshake as an ASCII line ("Fizz", "Buzz",
// "FizzBuzz" or a decimal number, then 0x0A) on a byte-wide valid/ready stream.
module fizzbuzz_ascii_tx #(
  parameter  int MAX_COUNT = 100,
  parameter  int DIGITS    = 3,
  localparam int W         = $clog2(MAX_COUNT) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         fizz,
  input  logic         buzz,
  input  logic         num,
  input  logic [W-1:0] number,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         proto_err
);

  localparam int CW = $clog2(W + 1);
  localparam int IW = $clog2(DIGITS + 9);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, EMIT} state_e;

  state_e          state_q, state_d;
  logic            fizz_q, fizz_d;
  logic            buzz_q, buzz_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            perr_q, perr_d;

  logic [BW-1:0]   adj;
  logic [BW+W-1:0] shifted;
  logic [IW-1:0]   ndig;
  logic [IW-1:0]   pos;
  logic [3:0]      cur_digit;
  logic            is_text;
  logic            line_end;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] word_char(input logic is_buzz, input logic [1:0] p);
    logic [7:0] c;
    case (p)
      2'd0:    c = is_buzz ? 8'h42 : 8'h46;
      2'd1:    c = is_buzz ? 8'h75 : 8'h69;
      default: c = 8'h7A;
    endcase
    return c;
  endfunction

  // Double-dabble step: correct every digit >= 5, then shift the next bit in.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    shifted = {adj, shift_q} << 1;
  end

  // Count of significant digits (at least one, so zero prints as "0").
  always_comb begin
    ndig = IW'(1);
    for (int i = 1; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) ndig = IW'(i + 1);
    end
    pos       = ndig - IW'(1) - idx_q;
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (pos == IW'(i)) cur_digit = bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    is_text = fizz_q | buzz_q;
    if (is_text) begin
      line_end = (idx_q == ((fizz_q && buzz_q) ? IW'(8) : IW'(4)));
      if (line_end)              cur_byte = 8'h0A;
      else if (fizz_q && buzz_q) cur_byte = word_char(idx_q >= IW'(4), idx_q[1:0]);
      else                       cur_byte = word_char(buzz_q, idx_q[1:0]);
    end else begin
      line_end = (idx_q == ndig);
      cur_byte = line_end ? 8'h0A : (8'h30 + {4'h0, cur_digit});
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign out_data  = out_valid ? cur_byte : 8'h00;
  assign out_last  = out_valid && line_end;
  assign proto_err = perr_q;

  // NOTE: every _d gets its hold value first, so no path through this block infers a latch.
  always_comb begin
    state_d = state_q;
    fizz_d  = fizz_q;
    buzz_d  = buzz_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    perr_d  = perr_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fizz_d  = fizz;
          buzz_d  = buzz;
          shift_d = number;
          bcd_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
          if (num != !(fizz | buzz)) perr_d = 1'b1;
          state_d = (fizz | buzz) ? EMIT : CONV;
        end
      end
      CONV: begin
        bcd_d   = shifted[BW+W-1:W];
        shift_d = shifted[W-1:0];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (line_end) state_d = IDLE;
          else          idx_d   = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fizz_q  <= 1'b0;
      buzz_q  <= 1'b0;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fizz_q  <= fizz_d;
      buzz_q  <= buzz_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_fizzbuzz_ascii_tx.sv
// Directed bench for fizzbuzz_ascii_tx: text lines, decimal lines, backpressure,
// mid-line reset, protocol error flag and the full 1..100 stream.
module tb_fizzbuzz_ascii_tx;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic         fizz, buzz, num;
  logic [W-1:0] number;
  logic         out_valid, out_ready, out_last, proto_err;
  logic [7:0]   out_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] got   [0:15];
  logic [7:0] exp_b [0:15];
  int got_n, exp_n;
  int lat, first_c, last_c;
  bit tmo, stab_err, last_err, rdy_err;

  fizzbuzz_ascii_tx #(.MAX_COUNT(100), .DIGITS(3)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .fizz(fizz), .buzz(buzz), .num(num), .number(number),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input bit use_got);
    string s = "";
    int n = use_got ? got_n : exp_n;
    for (int i = 0; i < n && i < 16; i++)
      s = {s, $sformatf("%02h ", use_got ? got[i] : exp_b[i])};
    return s;
  endfunction

  task automatic set_exp(input int n, input logic [71:0] v);
    exp_n = n;
    for (int i = 0; i < n; i++) exp_b[i] = v[8*(n-1-i) +: 8];
  endtask

  // Independent reference for one generator item.
  task automatic model_line(input int n);
    exp_n = 0;
    if (n % 3 == 0) begin
      exp_b[0] = "F"; exp_b[1] = "i"; exp_b[2] = "z"; exp_b[3] = "z"; exp_n = 4;
    end
    if (n % 5 == 0) begin
      exp_b[exp_n] = "B"; exp_b[exp_n+1] = "u"; exp_b[exp_n+2] = "z"; exp_b[exp_n+3] = "z";
      exp_n += 4;
    end
    if (exp_n == 0) begin
      if (n >= 100) begin exp_b[exp_n] = 8'(8'h30 + n / 100);       exp_n++; end
      if (n >= 10)  begin exp_b[exp_n] = 8'(8'h30 + (n / 10) % 10); exp_n++; end
      exp_b[exp_n] = 8'(8'h30 + n % 10); exp_n++;
    end
    exp_b[exp_n] = 8'h0A; exp_n++;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the cycle after accept.
  task automatic drive_accept(input bit f, input bit b, input bit n, input logic [W-1:0] v);
    in_valid = 1'b1; fizz = f; buzz = b; num = n; number = v;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; num = 1'b0; number = '0;
  endtask

  // Sink: collects one line, recording latency, gaps and handshake violations.
  task automatic collect(input int budget, input bit bp, input bit noise);
    int cyc = 1;
    bit held = 0, done = 0;
    logic [7:0] hd = 8'h00;
    logic hl = 1'b0;
    got_n = 0; lat = -1; first_c = -1; last_c = -1;
    stab_err = 0; last_err = 0; rdy_err = 0;
    while (!done && cyc <= budget) begin
      if (in_ready) rdy_err = 1;
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        if (held && (out_data !== hd || out_last !== hl)) stab_err = 1;
        if (out_last !== (out_data == 8'h0A)) last_err = 1;
        out_ready = bp ? ((cyc > lat) && ($urandom_range(0, 1) == 1)) : 1'b1;
        if (out_ready) begin
          if (got_n < 16) got[got_n] = out_data;
          got_n++;
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          held = 0;
          if (out_last) done = 1;
        end else begin
          held = 1; hd = out_data; hl = out_last;
        end
      end else if (held) begin
        stab_err = 1;
      end
      if (noise) begin in_valid = 1'b1; fizz = 1'b1; buzz = 1'b1; num = 1'b1; number = 8'd55; end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; num = 1'b0; number = '0;
    out_ready = 1'b1;
    tmo = !done;
  endtask

  // Per-line checks shared by the text and decimal scenarios, written out per test.
  task automatic test_reset;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
    total++;
    if (out_data !== 8'h00 || out_last !== 1'b0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs: data=%02h last=%b err=%b, required 00 0 0", out_data, out_last, proto_err);
    end
  endtask

  task automatic test_fizz;
    drive_accept(1, 0, 0, 8'd3);
    collect(40, 0, 0);
    set_exp(5, 72'h46697A7A0A);
    total++;
    if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
      bad++; $display("FAIL fizz_bytes: got %s(timeout=%b), required %s", fmt(1), tmo, fmt(0));
    end
    total++;
    if (lat != 1 || last_c - first_c + 1 != 5) begin
      bad++; $display("FAIL fizz_timing: latency=%0d span=%0d, required 1 5", lat, last_c - first_c + 1);
    end
    total++;
    if (last_err || rdy_err) begin
      bad++; $display("FAIL fizz_flags: last_err=%b in_ready_during_line=%b, required 0 0", last_err, rdy_err);
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL fizz_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fizzbuzz;
    drive_accept(1, 1, 0, 8'd15);
    collect(40, 0, 0);
    set_exp(9, 72'h46697A7A42757A7A0A);
    total++;
    if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
      bad++; $display("FAIL fizzbuzz_bytes: got %s(timeout=%b), required %s", fmt(1), tmo, fmt(0));
    end
    total++;
    if (lat != 1 || last_c - first_c + 1 != 9 || last_err || rdy_err) begin
      bad++; $display("FAIL fizzbuzz_timing: latency=%0d span=%0d last_err=%b rdy_err=%b, required 1 9 0 0",
                      lat, last_c - first_c + 1, last_err, rdy_err);
    end
    total++;
    if (proto_err !== 1'b0) begin
      bad++; $display("FAIL fizzbuzz_proto_err: got %b, required 0", proto_err);
    end
  endtask

  task automatic test_decimal;
    int          vals [5] = '{97, 100, 0, 7, 255};
    int          lens [5] = '{3, 4, 2, 2, 4};
    logic [71:0] pats [5] = '{72'h39370A, 72'h3130300A, 72'h300A, 72'h370A, 72'h3235350A};
    for (int k = 0; k < 5; k++) begin
      drive_accept(0, 0, 1, W'(vals[k]));
      collect(60, 0, (k == 0));
      set_exp(lens[k], pats[k]);
      total++;
      if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
        bad++; $display("FAIL dec_bytes_%0d: got %s(timeout=%b), required %s", vals[k], fmt(1), tmo, fmt(0));
      end
      total++;
      if (lat != W + 1 || last_c - first_c + 1 != lens[k] || last_err || rdy_err) begin
        bad++; $display("FAIL dec_timing_%0d: latency=%0d span=%0d last_err=%b rdy_err=%b, required %0d %0d 0 0",
                        vals[k], lat, last_c - first_c + 1, last_err, rdy_err, W + 1, lens[k]);
      end
    end
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || proto_err !== 1'b0) begin
      bad++; $display("FAIL dec_idle: in_ready=%b out_valid=%b err=%b, required 1 0 0", in_ready, out_valid, proto_err);
    end
  endtask

  task automatic test_backpressure;
    drive_accept(0, 0, 1, 8'd98);
    collect(300, 1, 0);
    set_exp(3, 72'h39380A);
    total++;
    if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
      bad++; $display("FAIL bp_bytes: got %s(timeout=%b), required %s", fmt(1), tmo, fmt(0));
    end
    total++;
    if (stab_err || last_err || rdy_err) begin
      bad++; $display("FAIL bp_stable: stab_err=%b last_err=%b rdy_err=%b, required 0 0 0", stab_err, last_err, rdy_err);
    end
  endtask

  task automatic test_reset_midline;
    drive_accept(1, 1, 0, 8'd15);
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h7A) begin
      bad++; $display("FAIL midline_third_byte: valid=%b data=%02h, required 1 7a", out_valid, out_data);
    end
    reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
      bad++; $display("FAIL midline_reset: out_valid=%b in_ready=%b last=%b, required 0 1 0", out_valid, in_ready, out_last);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive_accept(0, 0, 1, 8'd1);
    collect(60, 0, 0);
    set_exp(2, 72'h310A);
    total++;
    if (tmo || got_n != exp_n || fmt(1) != fmt(0) || lat != W + 1) begin
      bad++; $display("FAIL midline_next_line: got %s(timeout=%b latency=%0d), required %s latency %0d",
                      fmt(1), tmo, lat, fmt(0), W + 1);
    end
  endtask

  task automatic test_proto_err_stream;
    int line_bad = 0;
    drive_accept(1, 0, 1, 8'd3);
    total++;
    if (proto_err !== 1'b1) begin
      bad++; $display("FAIL perr_set: got %b, required 1", proto_err);
    end
    collect(40, 0, 0);
    set_exp(5, 72'h46697A7A0A);
    total++;
    if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
      bad++; $display("FAIL perr_line: got %s(timeout=%b), required %s", fmt(1), tmo, fmt(0));
    end
    for (int n = 1; n <= 100; n++) begin
      bit f = (n % 3 == 0);
      bit b = (n % 5 == 0);
      drive_accept(f, b, !(f | b), W'(n));
      collect(60, 0, 0);
      model_line(n);
      total++;
      if (tmo || got_n != exp_n || fmt(1) != fmt(0)) begin
        bad++; line_bad++;
        $display("FAIL stream_%0d: got %s(timeout=%b), required %s", n, fmt(1), tmo, fmt(0));
      end
      if (line_bad > 10) break;
    end
    total++;
    if (proto_err !== 1'b1) begin
      bad++; $display("FAIL perr_sticky: got %b, required 1", proto_err);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; fizz = 1'b0; buzz = 1'b0; num = 1'b0; number = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_fizz;
    test_fizzbuzz;
    test_decimal;
    test_backpressure;
    test_reset_midline;
    test_proto_err_stream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
